// File: rtl/burst_line_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : burst_line_writer_pkg
// Purpose  : Shared BurstRAM command encodings and write-back FSM state
//            constants, also used by the cache_data fill path.
// Contents : c_CMD_READ / c_CMD_WRITE  - br_cmd encodings
//            state_t, c_ST_*           - FSM state encoding (2 bits)
// Revision : 1.0 - initial release
// ============================================================================
package burst_line_writer_pkg;

    // BurstRAM command encodings
    localparam logic c_CMD_READ  = 1'b0;
    localparam logic c_CMD_WRITE = 1'b1;

    // FSM state encoding
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE     = 2'd0;
    localparam state_t c_ST_WAIT_RAM = 2'd1;
    localparam state_t c_ST_BURST    = 2'd2;
    localparam state_t c_ST_DONE     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/burst_line_writer.sv
`default_nettype none
// ============================================================================
// Module   : burst_line_writer
// Purpose  : Write-back engine for cache_data. Latches one dirty cache line
//            with its per-byte dirty mask and writes it to BurstRAM as one
//            write burst of RAM_BURST_DATA_COUNT beats.
// Ports    : clk, rst (sync, active high)
//            start, line_addr, line_data, line_dirty - write-back request
//            busy, done, stat_bursts                 - status
//            br_cmd, br_cmd_en, br_addr,
//            br_wr_data, br_data_mask, br_busy       - BurstRAM port
// Revision : 1.0 - initial release
// ============================================================================
module burst_line_writer
    import burst_line_writer_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        start,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]                               line_addr,
    input  logic [RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH-1:0]     line_data,
    input  logic [RAM_BURST_DATA_COUNT*RAM_BURST_DATA_BITWIDTH/8-1:0]   line_dirty,
    output logic                                                        busy,
    output logic                                                        done,
    output logic [31:0]                                                 stat_bursts,
    output logic                                                        br_cmd,
    output logic                                                        br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]                               br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]                          br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]                        br_data_mask,
    input  logic                                                        br_busy
);

    localparam int c_BW        = RAM_BURST_DATA_BITWIDTH;
    localparam int c_MW        = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int c_LINE_W    = RAM_BURST_DATA_COUNT * c_BW;
    localparam int c_DIRTY_W   = RAM_BURST_DATA_COUNT * c_MW;
    localparam int c_BEAT_BITS = $clog2(RAM_BURST_DATA_COUNT);
    localparam int c_CNT_W     = (RAM_BURST_DATA_COUNT > 1) ? c_BEAT_BITS : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(RAM_BURST_DATA_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    // Bursts are line aligned: the beat-select bits of the address are dropped
    localparam logic [RAM_DEPTH_BITWIDTH-1:0] c_ADDR_ALIGN =
        {RAM_DEPTH_BITWIDTH{1'b1}} << c_BEAT_BITS;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t                          r_state,      w_state_nxt;
    logic [c_LINE_W-1:0]             r_line_data,  w_line_data_nxt;
    logic [c_DIRTY_W-1:0]            r_line_dirty, w_line_dirty_nxt;
    logic [RAM_DEPTH_BITWIDTH-1:0]   r_line_addr,  w_line_addr_nxt;
    logic [c_CNT_W-1:0]              r_beat,       w_beat_nxt;
    logic                            r_issued,     w_issued_nxt;
    logic                            r_busy,       w_busy_nxt;
    logic                            r_done,       w_done_nxt;
    logic                            r_cmd,        w_cmd_nxt;
    logic                            r_cmd_en,     w_cmd_en_nxt;
    logic [RAM_DEPTH_BITWIDTH-1:0]   r_br_addr,    w_br_addr_nxt;
    logic [c_BW-1:0]                 r_wr_data,    w_wr_data_nxt;
    logic [c_MW-1:0]                 r_mask,       w_mask_nxt;
    logic [31:0]                     r_stat,       w_stat_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_line_data  <= '0;
            r_line_dirty <= '0;
            r_line_addr  <= '0;
            r_beat       <= '0;
            r_issued     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cmd        <= c_CMD_READ;
            r_cmd_en     <= 1'b0;
            r_br_addr    <= '0;
            r_wr_data    <= '0;
            r_mask       <= '1;
            r_stat       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_data  <= w_line_data_nxt;
            r_line_dirty <= w_line_dirty_nxt;
            r_line_addr  <= w_line_addr_nxt;
            r_beat       <= w_beat_nxt;
            r_issued     <= w_issued_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_cmd        <= w_cmd_nxt;
            r_cmd_en     <= w_cmd_en_nxt;
            r_br_addr    <= w_br_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_mask       <= w_mask_nxt;
            r_stat       <= w_stat_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. All RAM-port outputs are registered,
    // so each state computes what the port shows in the following cycle.
    // The line and dirty registers are shifted down one beat per issued beat,
    // so the current beat is always in the low bits.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_line_data_nxt  = r_line_data;
        w_line_dirty_nxt = r_line_dirty;
        w_line_addr_nxt  = r_line_addr;
        w_beat_nxt       = r_beat;
        w_issued_nxt     = r_issued;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_cmd_nxt        = r_cmd;
        w_cmd_en_nxt     = 1'b0;
        w_br_addr_nxt    = r_br_addr;
        w_wr_data_nxt    = r_wr_data;
        w_mask_nxt       = '1;
        w_stat_nxt       = r_stat;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_line_data_nxt  = line_data;
                    w_line_dirty_nxt = line_dirty;
                    w_line_addr_nxt  = line_addr & c_ADDR_ALIGN;
                    w_busy_nxt       = 1'b1;
                    w_issued_nxt     = 1'b0;
                    // A clean line needs no RAM traffic at all
                    w_state_nxt = (line_dirty == '0) ? c_ST_DONE : c_ST_WAIT_RAM;
                end
            end

            c_ST_WAIT_RAM: begin
                if (!br_busy) begin
                    w_cmd_en_nxt     = 1'b1;
                    w_cmd_nxt        = c_CMD_WRITE;
                    w_br_addr_nxt    = r_line_addr;
                    w_wr_data_nxt    = r_line_data[c_BW-1:0];
                    w_mask_nxt       = ~r_line_dirty[c_MW-1:0];
                    w_line_data_nxt  = r_line_data >> c_BW;
                    w_line_dirty_nxt = r_line_dirty >> c_MW;
                    w_beat_nxt       = c_ONE;
                    w_issued_nxt     = 1'b1;
                    w_state_nxt      = (c_LAST_BEAT == '0) ? c_ST_DONE : c_ST_BURST;
                end
            end

            c_ST_BURST: begin
                // Burst is committed: br_busy is not consulted here
                w_wr_data_nxt    = r_line_data[c_BW-1:0];
                w_mask_nxt       = ~r_line_dirty[c_MW-1:0];
                w_line_data_nxt  = r_line_data >> c_BW;
                w_line_dirty_nxt = r_line_dirty >> c_MW;
                if (r_beat == c_LAST_BEAT) begin
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_beat_nxt = r_beat + c_ONE;
                end
            end

            c_ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_ST_IDLE;
                if (r_issued) begin
                    w_stat_nxt = r_stat + 32'd1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign stat_bursts  = r_stat;
    assign br_cmd       = r_cmd;
    assign br_cmd_en    = r_cmd_en;
    assign br_addr      = r_br_addr;
    assign br_wr_data   = r_wr_data;
    assign br_data_mask = r_mask;

endmodule
`default_nettype wire
